// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive deserializer: FSM encodings,
// parity-type constants and the bit majority helper.
package uart_rx_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int LEN_MIN = 5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_sampler.sv
// Oversampling edge counter with a 3-point majority vote around mid-bit.
// o_bit_end marks the last oversample cycle of each bit period.
module uart_rx_edge_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      i_active,
  input  logic                      i_rx,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_bit_end,
  output logic                      o_voted
);

  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic                      r_s0;
  logic                      r_s1;
  logic                      r_voted;

  logic [PRESCALE_WIDTH-1:0] w_last;
  logic [PRESCALE_WIDTH-1:0] w_half;
  logic                      w_samp0;
  logic                      w_samp1;
  logic                      w_sample_done;

  assign w_last        = i_prescale - PRESCALE_WIDTH'(1);
  assign w_half        = i_prescale >> 1;
  assign w_samp0       = (r_edge_cnt == (w_half - PRESCALE_WIDTH'(1)));
  assign w_samp1       = (r_edge_cnt == w_half);
  assign w_sample_done = (r_edge_cnt == (w_half + PRESCALE_WIDTH'(1)));

  // The third sample is voted directly from the line, so the result is
  // registered on the sample_done cycle and usable from the next edge on.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_edge_cnt <= '0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_voted    <= 1'b0;
    end else if (!i_active) begin
      r_edge_cnt <= '0;
    end else begin
      if (r_edge_cnt == w_last) r_edge_cnt <= '0;
      else                      r_edge_cnt <= r_edge_cnt + PRESCALE_WIDTH'(1);
      if (w_samp0)       r_s0    <= i_rx;
      if (w_samp1)       r_s1    <= i_rx;
      if (w_sample_done) r_voted <= maj3(r_s0, r_s1, i_rx);
    end
  end

  assign o_bit_end = i_active && (r_edge_cnt == w_last);
  assign o_voted   = r_voted;

endmodule

// File: rtl/uart_rx_frame_deser.sv
// UART receive framer: start/data/parity/stop FSM with runtime length and
// bit order; results leave as single-cycle pulses one cycle after stop.
module uart_rx_frame_deser
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int LEN_WIDTH      = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      RX_EN,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [LEN_WIDTH-1:0]      data_len,
  input  logic                      msb_first,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err,
  output logic                      busy
);

  logic [2:0]                r_state;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [LEN_WIDTH-1:0]      r_len;
  logic                      r_msb;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic [LEN_WIDTH-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0]     r_sr;
  logic                      r_perr;
  logic [DATA_WIDTH-1:0]     r_p_data;
  logic                      r_data_valid;
  logic                      r_par_err;
  logic                      r_stp_err;

  logic                      w_bit_end;
  logic                      w_voted;
  logic [LEN_WIDTH-1:0]      w_shift;
  logic [DATA_WIDTH-1:0]     w_mask;
  logic [DATA_WIDTH-1:0]     w_aligned;
  logic                      w_par_exp;

  uart_rx_edge_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .CLK       (CLK),
    .RST       (RST),
    .i_active  (r_state != S_IDLE),
    .i_rx      (RX_IN),
    .i_prescale(r_prescale),
    .o_bit_end (w_bit_end),
    .o_voted   (w_voted)
  );

  // LSB-first words arrive at the top of the shifter and need right-justifying.
  assign w_shift   = LEN_WIDTH'(DATA_WIDTH) - r_len;
  assign w_mask    = ~({DATA_WIDTH{1'b1}} << r_len);
  assign w_aligned = (r_msb ? r_sr : (r_sr >> w_shift)) & w_mask;
  assign w_par_exp = (r_par_typ == PAR_ODD) ? ~(^w_aligned) : ^w_aligned;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_prescale   <= '0;
      r_len        <= '0;
      r_msb        <= 1'b0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_bit_cnt    <= '0;
      r_sr         <= '0;
      r_perr       <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      if (!RX_EN) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (!RX_IN) begin
            r_state    <= S_START;
            r_prescale <= prescale;
            r_len      <= data_len;
            r_msb      <= msb_first;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_bit_cnt  <= '0;
            r_sr       <= '0;
            r_perr     <= 1'b0;
          end
          S_START: if (w_bit_end) r_state <= w_voted ? S_IDLE : S_DATA;
          S_DATA: if (w_bit_end) begin
            r_sr      <= r_msb ? {r_sr[DATA_WIDTH-2:0], w_voted}
                               : {w_voted, r_sr[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + LEN_WIDTH'(1);
            if (r_bit_cnt == (r_len - LEN_WIDTH'(1)))
              r_state <= r_par_en ? S_PARITY : S_STOP;
          end
          S_PARITY: if (w_bit_end) begin
            r_perr  <= (w_voted != w_par_exp);
            r_state <= S_STOP;
          end
          S_STOP: if (w_bit_end) begin
            r_state <= S_IDLE;
            if (!w_voted || r_perr) begin
              r_stp_err <= !w_voted;
              r_par_err <= r_perr;
            end else begin
              r_data_valid <= 1'b1;
              r_p_data     <= w_aligned;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign P_DATA     = r_p_data;
  assign data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_deser.sv
// Directed bench for uart_rx_frame_deser: serial frames are driven bit by bit
// and each expected result pulse is queued and matched when it appears.
module tb_uart_rx_frame_deser;
  import uart_rx_pkg::*;

  localparam int W  = 8;
  localparam int PW = 6;
  localparam int LW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN;
  logic          RX_EN;
  logic [PW-1:0] prescale;
  logic [LW-1:0] data_len;
  logic          msb_first;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [W-1:0]  P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;

  uart_rx_frame_deser #(.DATA_WIDTH(W), .PRESCALE_WIDTH(PW), .LEN_WIDTH(LW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .RX_EN(RX_EN), .prescale(prescale),
    .data_len(data_len), .msb_first(msb_first), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .busy(busy)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // scoreboard entry: {dv, pe, se, p_data[7:0], pulse_cycle[31:0]}
  logic [42:0]  exp_q[$];
  logic [42:0]  mon_e;
  logic [W-1:0] last_good = '0;
  int           last_pulse = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && (data_valid || par_err || stp_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'b0, data_valid, par_err, stp_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_flags", {29'b0, data_valid, par_err, stp_err}, {29'b0, mon_e[42:40]});
        check("p_data", {24'b0, P_DATA}, {24'b0, mon_e[39:32]});
        check("pulse_cycle", cyc, mon_e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_bit(input int p, input logic v, input bit glitch);
    for (int j = 0; j < p; j++) begin
      RX_IN = (glitch && j == 5) ? ~v : v;
      tick(1);
    end
  endtask

  task automatic send_frame(input int p, input int len, input bit msb, input bit pe,
                            input bit pt, input logic [7:0] d, input bit flip_par,
                            input bit stop_v, input int glitch_bit);
    logic [7:0] dm;
    logic       par_bit;
    int         start;
    dm = d & 8'(((1 << len) - 1));
    prescale  = PW'(p);
    data_len  = LW'(len);
    msb_first = msb;
    PAR_EN    = pe;
    PAR_TYP   = pt;
    par_bit   = (^dm) ^ pt ^ flip_par;
    // the receiver can only leave IDLE the cycle after its previous pulse
    start = ((cyc + 1) > (last_pulse + 1)) ? (cyc + 1) : (last_pulse + 1);
    last_pulse = start + (2 + len + int'(pe)) * p;
    if (!stop_v || (pe && flip_par)) begin
      exp_q.push_back({1'b0, pe && flip_par, !stop_v, last_good, 32'(last_pulse)});
    end else begin
      exp_q.push_back({3'b100, dm, 32'(last_pulse)});
      last_good = dm;
    end
    drive_bit(p, 1'b0, 1'b0);
    for (int i = 0; i < len; i++)
      drive_bit(p, msb ? dm[len-1-i] : dm[i], glitch_bit == i);
    if (pe) drive_bit(p, par_bit, 1'b0);
    drive_bit(p, stop_v, 1'b0);
    RX_IN = 1'b1;
  endtask

  initial begin
    int rp, rl;
    RX_IN = 1'b1; RX_EN = 1'b0; prescale = 8; data_len = 8;
    msb_first = 1'b0; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN;
    tick(3);
    check("reset_p_data", {24'b0, P_DATA}, 32'd0);
    check("reset_flags", {29'b0, data_valid, par_err, stp_err}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    RST = 1'b0; RX_EN = 1'b1;
    tick(4);

    // 8N1 LSB-first
    send_frame(8, 8, 0, 0, PAR_EVEN, 8'hA5, 0, 1, -1);
    tick(4);
    check("idle_after_8n1", {31'b0, busy}, 32'd0);

    // MSB-first, 7 bits, even parity: good then corrupted parity
    send_frame(16, 7, 1, 1, PAR_EVEN, 8'h5A, 0, 1, -1);
    tick(4);
    send_frame(16, 7, 1, 1, PAR_EVEN, 8'h5A, 1, 1, -1);
    tick(4);

    // minimum length, odd parity, stop bit low
    send_frame(8, LEN_MIN, 0, 1, PAR_ODD, 8'h13, 0, 0, -1);
    tick(4);
    check("idle_after_stp_err", {31'b0, busy}, 32'd0);

    // short start pulse is rejected
    prescale = 8;
    RX_IN = 1'b0; tick(3); RX_IN = 1'b1;
    tick(12);
    check("start_glitch_abort", {31'b0, busy}, 32'd0);

    // one-cycle glitch on the centre sample of data bit 3
    send_frame(8, 8, 0, 0, PAR_EVEN, 8'h3C, 0, 1, 3);
    tick(4);

    // random legal frames
    for (int k = 0; k < 4; k++) begin
      rp = 8 << $urandom_range(0, 2);
      rl = $urandom_range(LEN_MIN, W);
      send_frame(rp, rl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 0, 1, -1);
      tick(3);
    end

    // back-to-back frames, no idle gap
    send_frame(8, 8, 0, 0, PAR_EVEN, 8'h00, 0, 1, -1);
    send_frame(8, 8, 0, 0, PAR_EVEN, 8'hFF, 0, 1, -1);
    tick(4);

    // reset mid-DATA
    prescale = 8; data_len = 8; msb_first = 1'b0; PAR_EN = 1'b0;
    RX_IN = 1'b0; tick(8); RX_IN = 1'b1; tick(8); RX_IN = 1'b0; tick(5);
    RST = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_p_data", {24'b0, P_DATA}, 32'd0);
    check("rst_flags", {29'b0, data_valid, par_err, stp_err}, 32'd0);
    RX_IN = 1'b1; last_good = '0;
    tick(2);
    RST = 1'b0;
    tick(4);

    // RX_EN dropped mid-frame
    RX_IN = 1'b0; tick(8); RX_IN = 1'b1; tick(6);
    RX_EN = 1'b0;
    tick(1);
    check("rx_en_drop_busy", {31'b0, busy}, 32'd0);
    tick(2);
    RX_EN = 1'b1;
    tick(20);
    check("rx_en_drop_idle", {31'b0, busy}, 32'd0);

    // clean frame after the aborts
    send_frame(8, 8, 0, 1, PAR_ODD, 8'hC3, 0, 1, -1);
    tick(4);

    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) tick(1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
